// File: rtl/boolean_sweep_pkg.sv
// rtl/boolean_sweep_pkg.sv - shared types and constants for the boolean_min sweep sequencer
package boolean_sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/boolean_sweep_ctrl.sv
// rtl/boolean_sweep_ctrl.sv - drives all {a,b,c} vectors into boolean_min and checks F against a truth table
module boolean_sweep_ctrl
    import boolean_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    input  logic                   f,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] result,
    output logic [NUM_VECTORS-1:0] mismatch,
    output logic                   pass
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_VECTORS-1:0] expected_q;
    logic [NUM_VECTORS-1:0] result_final;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (cnt == CNT_LAST) state_next = CAPTURE;
            CAPTURE: state_next = (idx == IDX_LAST) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Last vector's F merged in so mismatch/pass are already valid in the DONE cycle.
    always_comb begin
        result_final      = result;
        result_final[idx] = f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            expected_q <= '0;
            result     <= '0;
            mismatch   <= '0;
            pass       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        result     <= '0;
                        mismatch   <= '0;
                        pass       <= 1'b0;
                        idx        <= '0;
                        cnt        <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    result[idx] <= f;
                    if (idx != IDX_LAST) begin
                        idx <= idx + IDX_W'(1);
                        cnt <= '0;
                    end else begin
                        mismatch <= result_final ^ expected_q;
                        pass     <= (result_final == expected_q);
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        {a, b, c} = 3'b000;
        if (state == SETTLE || state == CAPTURE) begin
            {a, b, c} = idx;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// tb/tb_boolean_sweep_ctrl.sv - self-checking bench for boolean_sweep_ctrl at S=2, S=1 and S=255
module tb_boolean_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [3];
    logic [7:0] exp_v   [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       c_v     [3];
    logic       f_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] res_v   [3];
    logic [7:0] mis_v   [3];
    logic       pass_v  [3];
    logic [7:0] tt_v    [3];
    int         done_cnt[3];
    int         tests  = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for boolean_min: truth table lookup on {a,b,c}.
    assign f_v[0] = tt_v[0][{a_v[0], b_v[0], c_v[0]}];
    assign f_v[1] = tt_v[1][{a_v[1], b_v[1], c_v[1]}];
    assign f_v[2] = tt_v[2][{a_v[2], b_v[2], c_v[2]}];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    boolean_sweep_ctrl #(.SETTLE_CYCLES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .f(f_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(res_v[0]), .mismatch(mis_v[0]), .pass(pass_v[0])
    );
    boolean_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .f(f_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .result(res_v[1]), .mismatch(mis_v[1]), .pass(pass_v[1])
    );
    boolean_sweep_ctrl #(.SETTLE_CYCLES(255)) dut_s255 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .expected(exp_v[2]),
        .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .f(f_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .result(res_v[2]), .mismatch(mis_v[2]), .pass(pass_v[2])
    );

    typedef struct {
        logic [7:0] tt;
        logic [7:0] ex;
        logic [7:0] r_exp;
        logic [7:0] m_exp;
        logic       p_exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] tt_from_expr();
        logic [7:0] t;
        for (int k = 0; k < 8; k++) begin
            logic ai, bi, ci;
            ai = (k / 4) % 2 == 1;
            bi = (k / 2) % 2 == 1;
            ci = k % 2 == 1;
            t[k] = (ai & ~bi) | ci;
        end
        return t;
    endfunction

    function automatic logic [31:0] outs(input int i);
        return {a_v[i], b_v[i], c_v[i], busy_v[i], done_v[i], res_v[i], mis_v[i], pass_v[i]};
    endfunction

    task automatic sweep(input int i, input int s, input logic [7:0] tt, input logic [7:0] ex,
                         input bit poke, input logic [7:0] r_exp, input logic [7:0] m_exp,
                         input logic p_exp);
        int cyc;
        int d0;
        bit seq_ok;
        @(negedge clk);
        tt_v[i]    = tt;
        exp_v[i]   = ex;
        start_v[i] = 1'b1;
        d0         = done_cnt[i];
        @(negedge clk);
        start_v[i] = 1'b0;
        cyc        = 0;
        seq_ok     = 1'b1;
        while (!done_v[i] && cyc < 8 * (s + 1) + 4) begin
            if ({a_v[i], b_v[i], c_v[i]} != 3'(cyc / (s + 1)) || !busy_v[i]) seq_ok = 1'b0;
            if (poke && cyc == 10) begin
                start_v[i] = 1'b1;
                exp_v[i]   = 8'h00;
            end
            if (poke && cyc == 11) start_v[i] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("abc_seq[s=%0d]", s), 32'(seq_ok), 32'd1);
        chk($sformatf("done_latency[s=%0d]", s), cyc, 8 * (s + 1));
        chk("busy_in_done", 32'(busy_v[i]), 32'd1);
        chk("result", 32'(res_v[i]), 32'(r_exp));
        chk("mismatch", 32'(mis_v[i]), 32'(m_exp));
        chk("pass", 32'(pass_v[i]), 32'(p_exp));
        @(negedge clk);
        chk("after_done_ctrl", {29'd0, done_v[i], busy_v[i], a_v[i] | b_v[i] | c_v[i]}, 32'd0);
        chk("done_count", done_cnt[i] - d0, 1);
        repeat (3) @(negedge clk);
        chk("held", {15'd0, res_v[i], mis_v[i], pass_v[i]}, {15'd0, r_exp, m_exp, p_exp});
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] tt;
        logic [7:0] ex;
        logic [7:0] tbase;
        int         cyc;
        int         d0;

        tbase = tt_from_expr();
        vecs[0] = '{tbase, 8'hBA, tbase, 8'h00, 1'b1};
        vecs[1] = '{tbase, 8'hBB, tbase, 8'h01, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{8'h0F, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 8'h80, 8'h81, 8'h01, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i]  = 1'b0;
            exp_v[i]    = 8'h00;
            tt_v[i]     = 8'h00;
            done_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(0), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_outs", outs(0), 32'd0);
        end

        for (int v = 0; v < 6; v++) begin
            sweep(0, 2, vecs[v].tt, vecs[v].ex, 1'b0, vecs[v].r_exp, vecs[v].m_exp, vecs[v].p_exp);
        end

        // start re-pulsed and expected zeroed mid-sweep: original 8'hBA must be used
        sweep(0, 2, tbase, 8'hBA, 1'b1, 8'hBA, 8'h00, 1'b1);

        // asynchronous reset mid-sweep
        @(negedge clk);
        tt_v[0] = tbase; exp_v[0] = 8'hBA; start_v[0] = 1'b1;
        d0 = done_cnt[0];
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (cyc < 13) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_before_abort", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(0), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - d0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, 2, tbase, 8'hBA, 1'b0, 8'hBA, 8'h00, 1'b1);

        for (int r = 0; r < 6; r++) begin
            tt = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
            sweep(0, 2, tt, ex, 1'b0, tt, tt ^ ex, tt == ex);
        end

        sweep(1, 1, tbase, 8'hBA, 1'b0, 8'hBA, 8'h00, 1'b1);
        tt = 8'($urandom);
        sweep(1, 1, tt, 8'h5A, 1'b0, tt, tt ^ 8'h5A, tt == 8'h5A);
        sweep(2, 255, tbase, 8'hBA, 1'b0, 8'hBA, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
